// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the fetch PC sequencer: state encoding,
// PC step/alignment constants and counter widths.
// Pure definitions; no latency and no backpressure of its own.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Flush down-counter width: FLUSH_CYCLES is limited to 1..7.
  localparam int unsigned FLUSH_CNT_W = 3;

  // Branch statistics counter width (optional BRANCH_STATS_EN build).
  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Bus bundle between the PC sequencer and hazard unit / EX comparator / imem.
// Wires only; latency and backpressure are defined by the sequencer.
// master: sequencer side (drives pc, pc_add_4, imem_req, flush, taken).
// slave : environment side (drives imem_ready, stall, branch, bne, eq_res,
//         branch_pc, jump, jump_pc).
// Optional macro BRANCH_STATS_EN adds br_count / br_taken_count.
interface branch_pc_sequencer_if;
  import mips_ctrl_pkg::*;

  logic        imem_ready;
  logic        stall;
  logic        branch;
  logic        bne;
  logic        eq_res;
  logic [31:0] branch_pc;
  logic        jump;
  logic [31:0] jump_pc;
  logic [31:0] pc;
  logic [31:0] pc_add_4;
  logic        imem_req;
  logic        flush;
  logic        taken;
`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] br_count;
  logic [STATS_W-1:0] br_taken_count;
`endif

  modport master (
    input  imem_ready, stall, branch, bne, eq_res, branch_pc, jump, jump_pc,
`ifdef BRANCH_STATS_EN
    output br_count, br_taken_count,
`endif
    output pc, pc_add_4, imem_req, flush, taken
  );

  modport slave (
    output imem_ready, stall, branch, bne, eq_res, branch_pc, jump, jump_pc,
`ifdef BRANCH_STATS_EN
    input  br_count, br_taken_count,
`endif
    input  pc, pc_add_4, imem_req, flush, taken
  );

endinterface

// File: rtl/branch_pc_sequencer_branch_resolve.sv
// Resolves an EX-stage beq/bne into a taken decision.
// Purely combinational, zero latency.
// No backpressure.
// Ports: branch (valid), bne (1=bne, 0=beq), eq_res (operands equal) -> br_taken.
module branch_resolve (
  input  logic branch,
  input  logic bne,
  input  logic eq_res,
  output logic br_taken
);

  assign br_taken = branch & (bne ? ~eq_res : eq_res);

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC register and branch/jump redirect sequencer with wrong-path flush.
// Latency: redirect sampled at edge N -> pc = target after edge N; flush for
//   FLUSH_CYCLES cycles after that. Backpressure: stall or !imem_ready holds pc
//   in FETCH (a redirect still wins); only imem_ready gates pc during FLUSH.
// Ports: clk, rst_n (sync, active-low), bus (branch_pc_sequencer_if.master).
// Optional macro BRANCH_STATS_EN adds saturating br_count / br_taken_count.
module branch_pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_pc_sequencer_if.master  bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES);

  seq_state_t             state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            pc_add_4_q, pc_add_4_d;
  logic                   taken_q, taken_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   br_taken;
  logic                   redirect;
  logic [31:0]            target;
  logic                   imem_req;
  logic                   flush;

  branch_resolve u_resolve (
    .branch   (bus.branch),
    .bne      (bus.bne),
    .eq_res   (bus.eq_res),
    .br_taken (br_taken)
  );

  // The EX branch is older than the ID jump, so it takes the redirect slot.
  assign redirect = br_taken | bus.jump;
  assign target   = (br_taken ? bus.branch_pc : bus.jump_pc) & PC_ALIGN_MASK;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    taken_d  = 1'b0;
    imem_req = 1'b0;
    flush    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = ~bus.stall;
        if (redirect) begin
          pc_d    = target;
          taken_d = 1'b1;
          cnt_d   = FLUSH_INIT;
          state_d = ST_FLUSH;
        end else if (~bus.stall & bus.imem_ready) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_FLUSH: begin
        // Squashed stages raise no hazards and their branches/jumps are dead.
        flush    = 1'b1;
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          pc_d = pc_q + PC_STEP;
        end
        if (cnt_q <= FLUSH_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    pc_add_4_d = pc_d + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_add_4_q <= RESET_PC + PC_STEP;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_add_4_q <= pc_add_4_d;
      taken_q    <= taken_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_add_4 = pc_add_4_q;
  assign bus.imem_req = imem_req;
  assign bus.flush    = flush;
  assign bus.taken    = taken_q;

`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] br_count_q, br_count_d;
  logic [STATS_W-1:0] br_taken_count_q, br_taken_count_d;

  // Only branches seen in FETCH are real; FLUSH-cycle branches are squashed.
  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    if (state_q == ST_FETCH) begin
      if (bus.branch && (br_count_q != '1)) begin
        br_count_d = br_count_q + STATS_W'(1);
      end
      if (br_taken && (br_taken_count_q != '1)) begin
        br_taken_count_d = br_taken_count_q + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
    end else begin
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
    end
  end

  assign bus.br_count       = br_count_q;
  assign bus.br_taken_count = br_taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed vector table, a
// mid-flush reset sequence, then randomized cycles against a reference model.
module tb_branch_pc_sequencer;

  localparam int FLUSH_N = 2;

  logic clk;
  logic rst_n;

  branch_pc_sequencer_if bus_if ();

  branch_pc_sequencer #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic        bne;
    logic        eq;
    logic [31:0] bpc;
    logic        jmp;
    logic [31:0] jpc;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_fl;
    logic        e_tk;
    logic        e_req;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: remaining flush cycles rather than an FSM.
  logic [31:0] m_pc;
  bit          m_boot;
  int          m_fl_left;
  bit          m_tk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.stall     = v.stall;
    bus_if.branch    = v.br;
    bus_if.bne       = v.bne;
    bus_if.eq_res    = v.eq;
    bus_if.branch_pc = v.bpc;
    bus_if.jump      = v.jmp;
    bus_if.jump_pc   = v.jpc;
    bus_if.imem_ready = v.rdy;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_step();
    bit bt;
    if (!rst_n) begin
      m_pc = 32'h0; m_boot = 1; m_fl_left = 0; m_tk = 0;
    end else if (m_boot) begin
      m_boot = 0; m_tk = 0;
    end else if (m_fl_left > 0) begin
      m_fl_left--; m_tk = 0;
      if (bus_if.imem_ready) m_pc = m_pc + 32'd4;
    end else begin
      bt = bus_if.branch && (bus_if.bne ? !bus_if.eq_res : bus_if.eq_res);
      if (bt || bus_if.jump) begin
        m_pc = (bt ? bus_if.branch_pc : bus_if.jump_pc);
        m_pc = {m_pc[31:2], 2'b00};
        m_fl_left = FLUSH_N;
        m_tk = 1;
      end else begin
        m_tk = 0;
        if (!bus_if.stall && bus_if.imem_ready) m_pc = m_pc + 32'd4;
      end
    end
  endtask

  vec_t tbl[29];

  initial begin
    vec_t idle;
    vec_t rv;
    bit   exp_req;
    idle = '{stall:0, br:0, bne:0, eq:0, bpc:0, jmp:0, jpc:0, rdy:1,
             e_pc:0, e_fl:0, e_tk:0, e_req:0};

    //              st br bne eq bpc           jmp jpc           rdy e_pc          fl tk req
    tbl[0]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 0}; // BOOT
    tbl[1]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 1, 32'h40,       0, 32'h0,        1, 32'h0000_0010, 0, 0, 1}; // beq taken
    tbl[6]  = '{1, 0, 0, 0, 32'h0,        1, 32'h200,      1, 32'h0000_0040, 1, 1, 1}; // jump/stall ignored
    tbl[7]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0044, 1, 0, 1};
    tbl[8]  = '{0, 1, 1, 1, 32'h80,       0, 32'h0,        1, 32'h0000_0048, 0, 0, 1}; // bne not taken
    tbl[9]  = '{0, 1, 1, 0, 32'h80,       0, 32'h0,        1, 32'h0000_004C, 0, 0, 1}; // bne taken
    tbl[10] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0080, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0084, 1, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0088, 0, 0, 0}; // stall
    tbl[13] = '{1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0088, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0088, 0, 0, 1}; // !ready
    tbl[15] = '{1, 1, 0, 1, 32'h20,       0, 32'h0,        1, 32'h0000_0088, 0, 0, 0}; // stall + beq
    tbl[16] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0020, 1, 1, 1};
    tbl[17] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0024, 1, 0, 1};
    tbl[18] = '{0, 1, 0, 1, 32'h100,      1, 32'h200,      1, 32'h0000_0028, 0, 0, 1}; // priority
    tbl[19] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0100, 1, 1, 1};
    tbl[20] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0104, 1, 0, 1};
    tbl[21] = '{0, 0, 0, 0, 32'h0,        1, 32'h43,       1, 32'h0000_0108, 0, 0, 1}; // alignment
    tbl[22] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0040, 1, 1, 1};
    tbl[23] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0044, 1, 0, 1};
    tbl[24] = '{0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0000_0048, 0, 0, 1};
    tbl[25] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 1, 1, 1}; // hold in flush
    tbl[26] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 1, 0, 1};
    tbl[27] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 1}; // wrap
    tbl[28] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 1};

    // Reset held for two edges.
    rst_n = 1'b0;
    drive(idle);
    next_edge();
    next_edge();
    chk("rst_pc",       bus_if.pc,       32'h0);
    chk("rst_pc_add_4", bus_if.pc_add_4, 32'h4);
    chk("rst_imem_req", 32'(bus_if.imem_req), 32'h0);
    chk("rst_flush",    32'(bus_if.flush),    32'h0);
    chk("rst_taken",    32'(bus_if.taken),    32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d_pc", i),       bus_if.pc,       tbl[i].e_pc);
      chk($sformatf("vec%0d_pc_add_4", i), bus_if.pc_add_4, tbl[i].e_pc + 32'd4);
      chk($sformatf("vec%0d_flush", i),    32'(bus_if.flush),    32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_taken", i),    32'(bus_if.taken),    32'(tbl[i].e_tk));
      chk($sformatf("vec%0d_imem_req", i), 32'(bus_if.imem_req), 32'(tbl[i].e_req));
      next_edge();
    end

    // Reset asserted mid-flush together with a jump: reset must win.
    rv = idle;
    rv.jmp = 1; rv.jpc = 32'h300;
    drive(rv);
    next_edge();
    chk("midrst_flush_before", 32'(bus_if.flush), 32'h1);
    rst_n = 1'b0;
    next_edge();
    chk("midrst_pc",       bus_if.pc,       32'h0);
    chk("midrst_pc_add_4", bus_if.pc_add_4, 32'h4);
    chk("midrst_flush",    32'(bus_if.flush),    32'h0);
    chk("midrst_taken",    32'(bus_if.taken),    32'h0);
    chk("midrst_imem_req", 32'(bus_if.imem_req), 32'h0);
    rst_n = 1'b1;
    drive(idle);
    m_pc = 32'h0; m_boot = 1; m_fl_left = 0; m_tk = 0;

    // Randomized phase against the reference model.
    for (int c = 0; c < 2000; c++) begin
      rv.stall = ($urandom_range(0, 3) == 0);
      rv.br    = ($urandom_range(0, 3) == 0);
      rv.bne   = 1'($urandom);
      rv.eq    = 1'($urandom);
      rv.bpc   = $urandom;
      rv.jmp   = ($urandom_range(0, 5) == 0);
      rv.jpc   = $urandom;
      rv.rdy   = ($urandom_range(0, 4) != 0);
      drive(rv);
      rst_n = ($urandom_range(0, 63) != 0);
      #2;
      exp_req = m_boot ? 1'b0 : (m_fl_left > 0) ? 1'b1 : !rv.stall;
      chk("rnd_pc",       bus_if.pc,       m_pc);
      chk("rnd_pc_add_4", bus_if.pc_add_4, m_pc + 32'd4);
      chk("rnd_flush",    32'(bus_if.flush),    32'((m_fl_left > 0) && !m_boot));
      chk("rnd_taken",    32'(bus_if.taken),    32'(m_tk));
      chk("rnd_imem_req", 32'(bus_if.imem_req), 32'(exp_req));
      model_step();
      next_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
